// File: rtl/counter_sequence_checker.sv
// Sequence checker for a binary counter bus: locks onto a run of +/-1 steps,
// then flags and counts breaks in sequence and marks wrap-around while locked.
module counter_sequence_checker #(
  parameter int WIDTH       = 4,
  parameter bit DIR         = 1'b0,
  parameter int LOCK_THRESH = 4,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             wrap_pulse,
  output logic [WIDTH-1:0] expected
);

  localparam int RUN_W = $clog2(LOCK_THRESH + 1);
  localparam logic [WIDTH-1:0] WRAP_VAL = DIR ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] step_from_prev;
  logic [WIDTH-1:0] step_from_in;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_nxt;
  logic [RUN_W-1:0] run_inc;
  logic             good;
  logic             err_nxt;
  logic             wrap_nxt;
  logic [ERR_W-1:0] err_count_nxt;

  // Arithmetic wraps naturally at WIDTH bits, so 15->0 (up) and 0->15 (down) are good steps.
  always_comb begin
    if (DIR) begin
      step_from_prev = prev - WIDTH'(1);
      step_from_in   = cnt_in - WIDTH'(1);
    end else begin
      step_from_prev = prev + WIDTH'(1);
      step_from_in   = cnt_in + WIDTH'(1);
    end
  end

  assign good    = (cnt_in == step_from_prev);
  assign run_inc = run + RUN_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    case (state)
      IDLE: begin
        state_nxt = ACQUIRE;
        run_nxt   = '0;
      end
      ACQUIRE: begin
        if (good) begin
          run_nxt = run_inc;
          if (run_inc == RUN_W'(LOCK_THRESH)) begin
            state_nxt = LOCKED;
          end
        end else begin
          run_nxt = '0;
        end
      end
      LOCKED: begin
        // A break drops lock and resynchronises on the offending value.
        if (!good) begin
          state_nxt = ACQUIRE;
          run_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        run_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    err_nxt       = 1'b0;
    wrap_nxt      = 1'b0;
    err_count_nxt = err_count;
    if (state == LOCKED) begin
      if (!good) begin
        err_nxt = 1'b1;
        if (err_count != {ERR_W{1'b1}}) begin
          err_count_nxt = err_count + ERR_W'(1);
        end
      end else if (cnt_in == WRAP_VAL) begin
        wrap_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev       <= '0;
      run        <= '0;
      expected   <= '0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      err_count  <= '0;
    end else begin
      prev       <= cnt_in;
      run        <= run_nxt;
      expected   <= step_from_in;
      err_pulse  <= err_nxt;
      wrap_pulse <= wrap_nxt;
      err_count  <= err_count_nxt;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_counter_sequence_checker.sv
// Directed bench for counter_sequence_checker: up, down and narrow-error-counter
// instances share one stimulus bus and are checked in separate phases.
module tb_counter_sequence_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] cnt = '0;

  logic       locked_u, err_pulse_u, wrap_pulse_u;
  logic [7:0] err_count_u;
  logic [3:0] expected_u;

  logic       locked_d, err_pulse_d, wrap_pulse_d;
  logic [7:0] err_count_d;
  logic [3:0] expected_d;

  logic       locked_e, err_pulse_e, wrap_pulse_e;
  logic [1:0] err_count_e;
  logic [3:0] expected_e;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  counter_sequence_checker #(.WIDTH(4), .DIR(1'b0), .LOCK_THRESH(4), .ERR_W(8)) dut_up (
    .clk(clk), .rst(rst), .cnt_in(cnt), .locked(locked_u), .err_pulse(err_pulse_u),
    .err_count(err_count_u), .wrap_pulse(wrap_pulse_u), .expected(expected_u)
  );

  counter_sequence_checker #(.WIDTH(4), .DIR(1'b1), .LOCK_THRESH(4), .ERR_W(8)) dut_dn (
    .clk(clk), .rst(rst), .cnt_in(cnt), .locked(locked_d), .err_pulse(err_pulse_d),
    .err_count(err_count_d), .wrap_pulse(wrap_pulse_d), .expected(expected_d)
  );

  counter_sequence_checker #(.WIDTH(4), .DIR(1'b0), .LOCK_THRESH(4), .ERR_W(2)) dut_e2 (
    .clk(clk), .rst(rst), .cnt_in(cnt), .locked(locked_e), .err_pulse(err_pulse_e),
    .err_count(err_count_e), .wrap_pulse(wrap_pulse_e), .expected(expected_e)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] want);
    tests_run++;
    if (actual !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, want);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v);
    cnt = v;
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] v;
    int exp_sat [5] = '{1, 2, 3, 3, 3};

    // Reset state and lock acquisition (up)
    applyReset();
    checkOutput("rst_locked", locked_u, 0);
    checkOutput("rst_err_pulse", err_pulse_u, 0);
    checkOutput("rst_wrap_pulse", wrap_pulse_u, 0);
    checkOutput("rst_err_count", err_count_u, 0);
    checkOutput("rst_expected", expected_u, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'(i));
      checkOutput("acq_locked_low", locked_u, 0);
    end
    applyStimulus(4'd4);
    checkOutput("acq_locked_high", locked_u, 1);
    checkOutput("acq_expected", expected_u, 5);
    checkOutput("acq_err_count", err_count_u, 0);

    // Break while locked, then relock
    applyStimulus(4'd5);
    applyStimulus(4'd6);
    applyStimulus(4'd7);
    checkOutput("pre_break_locked", locked_u, 1);
    applyStimulus(4'd9);
    checkOutput("break_err_pulse", err_pulse_u, 1);
    checkOutput("break_err_count", err_count_u, 1);
    checkOutput("break_locked", locked_u, 0);
    checkOutput("break_expected", expected_u, 10);
    applyStimulus(4'd10);
    checkOutput("break_pulse_once", err_pulse_u, 0);
    applyStimulus(4'd11);
    applyStimulus(4'd12);
    checkOutput("relock_low_12", locked_u, 0);
    applyStimulus(4'd13);
    checkOutput("relock_high_13", locked_u, 1);
    checkOutput("relock_err_pulse", err_pulse_u, 0);
    checkOutput("relock_err_count", err_count_u, 1);

    // Wrap while locked (up)
    applyStimulus(4'd14);
    checkOutput("wrap_14", wrap_pulse_u, 0);
    applyStimulus(4'd15);
    checkOutput("wrap_15", wrap_pulse_u, 0);
    applyStimulus(4'd0);
    checkOutput("wrap_0", wrap_pulse_u, 1);
    checkOutput("wrap_0_locked", locked_u, 1);
    checkOutput("wrap_0_err", err_pulse_u, 0);
    applyStimulus(4'd1);
    checkOutput("wrap_1", wrap_pulse_u, 0);
    checkOutput("wrap_1_locked", locked_u, 1);

    // Down-counting instance: lock and wrap 0 -> 15
    applyReset();
    applyStimulus(4'd5);
    applyStimulus(4'd4);
    applyStimulus(4'd3);
    applyStimulus(4'd2);
    checkOutput("dn_locked_low", locked_d, 0);
    applyStimulus(4'd1);
    checkOutput("dn_locked_high", locked_d, 1);
    checkOutput("dn_expected", expected_d, 0);
    applyStimulus(4'd0);
    checkOutput("dn_wrap_0", wrap_pulse_d, 0);
    applyStimulus(4'd15);
    checkOutput("dn_wrap_15", wrap_pulse_d, 1);
    checkOutput("dn_expected_14", expected_d, 14);
    checkOutput("dn_locked_15", locked_d, 1);
    applyStimulus(4'd14);
    checkOutput("dn_wrap_14", wrap_pulse_d, 0);
    checkOutput("dn_err_count", err_count_d, 0);

    // Saturating 2-bit error counter
    applyReset();
    for (int i = 0; i < 5; i++) applyStimulus(4'(i));
    checkOutput("e2_locked", locked_e, 1);
    v = 4'd4;
    for (int k = 0; k < 5; k++) begin
      v = v + 4'd2;
      applyStimulus(v);
      checkOutput("e2_err_pulse", err_pulse_e, 1);
      checkOutput("e2_err_count", err_count_e, 32'(exp_sat[k]));
      for (int j = 0; j < 4; j++) begin
        v = v + 4'd1;
        applyStimulus(v);
      end
      checkOutput("e2_relock", locked_e, 1);
      checkOutput("e2_pulse_clear", err_pulse_e, 0);
    end

    // Mid-operation reset with err_count = 2
    applyReset();
    for (int i = 0; i < 5; i++) applyStimulus(4'(i));
    v = 4'd4;
    for (int k = 0; k < 2; k++) begin
      v = v + 4'd2;
      applyStimulus(v);
      for (int j = 0; j < 4; j++) begin
        v = v + 4'd1;
        applyStimulus(v);
      end
    end
    checkOutput("mr_pre_count", err_count_u, 2);
    checkOutput("mr_pre_locked", locked_u, 1);
    v = v + 4'd1;
    rst = 1'b1;
    applyStimulus(v);
    rst = 1'b0;
    checkOutput("mr_locked", locked_u, 0);
    checkOutput("mr_err_pulse", err_pulse_u, 0);
    checkOutput("mr_wrap_pulse", wrap_pulse_u, 0);
    checkOutput("mr_err_count", err_count_u, 0);
    checkOutput("mr_expected", expected_u, 0);
    for (int i = 0; i < 5; i++) begin
      v = v + 4'd1;
      applyStimulus(v);
      checkOutput("mr_relock", locked_u, (i == 4) ? 1 : 0);
    end

    // Stalled counter at 6 (sequence above ends on 6)
    checkOutput("stall_start_val", expected_u, 7);
    applyStimulus(v);
    checkOutput("stall1_err_pulse", err_pulse_u, 1);
    checkOutput("stall1_err_count", err_count_u, 1);
    checkOutput("stall1_locked", locked_u, 0);
    applyStimulus(v);
    checkOutput("stall2_err_pulse", err_pulse_u, 0);
    checkOutput("stall2_err_count", err_count_u, 1);
    checkOutput("stall2_locked", locked_u, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
